// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes several source FIFOs onto one UART
// transmitter and forwards up to BURST_LENGTH words per grant.
module uart_tx_arbiter #(
  parameter int unsigned NUM_CHANNELS = 32'd4,
  parameter int unsigned WORD_WIDTH   = 32'd8,
  parameter int unsigned BURST_LENGTH = 32'd2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] src_din,
  input  logic [NUM_CHANNELS-1:0]            src_empty,
  output logic [NUM_CHANNELS-1:0]            src_re,
  output logic [WORD_WIDTH-1:0]              din,
  output logic                               empty,
  input  logic                               re,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] grant_id,
  output logic                               grant_valid
);

  localparam int unsigned GID_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_LENGTH + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LENGTH);
  localparam logic [GID_W-1:0] LAST_CH   = GID_W'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_OFFER,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [GID_W-1:0]      r_grant_id;
  logic [GID_W-1:0]      r_last_grant;
  logic [GID_W-1:0]      w_rr_pick;
  logic                  w_rr_found;
  logic [CNT_W-1:0]      r_word_count;
  logic [WORD_WIDTH-1:0] r_word;
  logic [WORD_WIDTH-1:0] w_chan_din [NUM_CHANNELS];
  logic                  w_granted_ready;
  logic                  w_burst_more;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_unpack
    assign w_chan_din[k] = src_din[k*WORD_WIDTH +: WORD_WIDTH];
  end

  assign w_granted_ready = ~src_empty[r_grant_id];
  assign w_burst_more    = (r_word_count < BURST_MAX) && w_granted_ready;

  // First non-empty channel scanning upward from the one after the last grant.
  always_comb begin
    int unsigned cand;
    cand       = '0;
    w_rr_found = 1'b0;
    w_rr_pick  = '0;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      cand = 32'(r_last_grant) + i;
      if (cand >= NUM_CHANNELS) begin
        cand = cand - NUM_CHANNELS;
      end
      if (!w_rr_found && !src_empty[cand[GID_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = cand[GID_W-1:0];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    src_re       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rr_found) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_granted_ready) begin
          w_next_state       = S_CAPTURE;
          src_re[r_grant_id] = ~rst;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CAPTURE: w_next_state = S_OFFER;
      S_OFFER: begin
        if (re) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN:   w_next_state = w_burst_more ? S_FETCH : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
    if (rst) begin
      w_next_state = S_IDLE;
    end
  end

  // A word held in S_OFFER at reset is simply dropped; the FIFO already gave it up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= LAST_CH;
      r_word_count <= '0;
      r_word       <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_rr_found) begin
            r_grant_id   <= w_rr_pick;
            r_word_count <= '0;
          end
        end
        S_FETCH: begin
          if (!w_granted_ready) begin
            r_last_grant <= r_grant_id;
          end
        end
        S_CAPTURE: r_word <= w_chan_din[r_grant_id];
        S_OFFER: begin
          if (re) begin
            r_word_count <= r_word_count + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (!w_burst_more) begin
            r_last_grant <= r_grant_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign din         = r_word;
  assign empty       = (r_state != S_OFFER);
  assign grant_valid = (r_state != S_IDLE);
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: FIFO models feed the arbiter, a transaction-level
// round-robin model predicts the word/grant order checked every cycle.
module tb_uart_tx_arbiter;

  localparam int NCH = 4;
  localparam int WW  = 8;
  localparam int BL  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*WW-1:0] src_din = '0;
  logic [NCH-1:0]    src_empty;
  logic [NCH-1:0]    src_re;
  logic [WW-1:0]     din;
  logic              empty;
  logic              re = 1'b0;
  logic [1:0]        grant_id;
  logic              grant_valid;

  uart_tx_arbiter #(
    .NUM_CHANNELS(NCH),
    .WORD_WIDTH  (WW),
    .BURST_LENGTH(BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_din    (src_din),
    .src_empty  (src_empty),
    .src_re     (src_re),
    .din        (din),
    .empty      (empty),
    .re         (re),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  // Source FIFO models: data appears the cycle after the read enable.
  logic [WW-1:0] fifoMem [NCH][16];
  int            fifoHead [NCH];
  int            fifoTail [NCH];

  always_comb begin
    for (int k = 0; k < NCH; k++) src_empty[k] = (fifoHead[k] == fifoTail[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (src_re[k] && fifoHead[k] != fifoTail[k]) begin
        src_din[k*WW +: WW] <= fifoMem[k][fifoHead[k]];
        fifoHead[k]         <= fifoHead[k] + 1;
      end
    end
  end

  int            vecCount = 0;
  int            missCount = 0;
  logic [WW-1:0] expWord[$];
  int            expGid[$];
  int            mLastGrant = NCH - 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [WW-1:0] w);
    fifoMem[ch][fifoTail[ch]] = w;
    fifoTail[ch] = fifoTail[ch] + 1;
  endtask

  task automatic expectWord(input logic [WW-1:0] w, input int ch);
    expWord.push_back(w);
    expGid.push_back(ch);
  endtask

  // Plays round-robin with bursts over the current FIFO contents.
  task automatic planFromFifos();
    int ptr [NCH];
    int left;
    int ch;
    left = 0;
    for (int k = 0; k < NCH; k++) begin
      ptr[k] = fifoHead[k];
      left  += fifoTail[k] - fifoHead[k];
    end
    while (left > 0) begin
      ch = (mLastGrant + 1) % NCH;
      while (ptr[ch] == fifoTail[ch]) ch = (ch + 1) % NCH;
      for (int b = 0; b < BL && ptr[ch] != fifoTail[ch]; b++) begin
        expectWord(fifoMem[ch][ptr[ch]], ch);
        ptr[ch]++;
        left--;
      end
      mLastGrant = ch;
    end
  endtask

  logic          checkEnable = 1'b0;
  logic          reAlways = 1'b0;
  int            reDelay = 0;
  int            waitCount = 0;
  logic          pendingDrain = 1'b0;
  logic [WW-1:0] lastWord = '0;
  logic          prevValid = 1'b0;
  logic [1:0]    prevGid = '0;

  // Per-cycle comparison against the model plus the transmitter-side re driver.
  always @(negedge clk) begin
    if (!checkEnable) begin
      re           = 1'b0;
      waitCount    = 0;
      pendingDrain = 1'b0;
      prevValid    = 1'b0;
    end else begin
      if (src_re != '0) begin
        checkOutput("srcReOneHot", src_re, 4'b0001 << grant_id);
        checkOutput("srcReValid", grant_valid, 1);
        if (expGid.size() > 0) checkOutput("srcReGrant", grant_id, expGid[0]);
        else checkOutput("srcReUnexpected", src_re, 0);
      end
      if (prevValid && grant_valid) checkOutput("grantStable", grant_id, prevGid);
      if (pendingDrain) begin
        checkOutput("drainEmpty", empty, 1);
        checkOutput("drainDin", din, lastWord);
        checkOutput("drainValid", grant_valid, 1);
      end
      if (!empty) begin
        if (expWord.size() == 0) begin
          checkOutput("offerUnexpected", empty, 1);
        end else begin
          checkOutput("offerDin", din, expWord[0]);
          checkOutput("offerGrant", grant_id, expGid[0]);
          checkOutput("offerValid", grant_valid, 1);
        end
      end
      re           = reAlways || (!empty && waitCount >= reDelay);
      pendingDrain = 1'b0;
      if (!empty) begin
        if (re) begin
          waitCount    = 0;
          pendingDrain = 1'b1;
          if (expWord.size() > 0) begin
            lastWord = expWord.pop_front();
            void'(expGid.pop_front());
          end
        end else begin
          waitCount++;
        end
      end
      prevValid = grant_valid;
      prevGid   = grant_id;
    end
  end

  task automatic applyReset(input int cycles);
    checkEnable = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    expWord.delete();
    expGid.delete();
    mLastGrant = NCH - 1;
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstValid", grant_valid, 0);
    checkOutput("rstDin", din, 0);
    checkOutput("rstSrcRe", src_re, 0);
    checkEnable = 1'b1;
  endtask

  task automatic waitDrained(input string name, input int budget);
    int n;
    n = 0;
    while ((expWord.size() != 0 || grant_valid || !empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput({name, "Drained"}, expWord.size(), 0);
    checkOutput({name, "Idle"}, grant_valid, 0);
  endtask

  logic [WW-1:0] t4Exp [8] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("idleGid", grant_id, 0);
    for (int c = 0; c < 20; c++) begin
      checkOutput("idleEmpty", empty, 1);
      checkOutput("idleSrcRe", src_re, 0);
      checkOutput("idleDin", din, 0);
      checkOutput("idleValid", grant_valid, 0);
      @(negedge clk);
    end
    checkEnable = 1'b1;

    // Single word on channel 2, with exact cycle timing.
    applyStimulus(2, 8'h3C);
    planFromFifos();
    checkOutput("t2PlanGid", expGid[0], 2);
    @(negedge clk); checkOutput("t2SrcRe", src_re, 4'b0100);
    @(negedge clk); checkOutput("t2SrcReOff", src_re, 4'b0000);
    @(negedge clk); checkOutput("t2OfferEmpty", empty, 0); checkOutput("t2OfferDin", din, 8'h3C);
    @(negedge clk); checkOutput("t2DrainEmpty", empty, 1); checkOutput("t2DrainDin", din, 8'h3C);
    waitDrained("t2", 50);

    // Burst limit forces A3 to wait behind B1.
    applyStimulus(0, 8'hA1); applyStimulus(0, 8'hA2); applyStimulus(0, 8'hA3);
    applyStimulus(1, 8'hB1);
    planFromFifos();
    checkOutput("t3Plan0", expWord[0], 8'hA1);
    checkOutput("t3Plan1", expWord[1], 8'hA2);
    checkOutput("t3Plan2", expWord[2], 8'hB1);
    checkOutput("t3Plan3", expWord[3], 8'hA3);
    checkOutput("t3PlanGid2", expGid[2], 1);
    waitDrained("t3", 100);

    // All channels loaded after reset, re held high throughout.
    applyReset(2);
    for (int k = 0; k < NCH; k++) begin
      applyStimulus(k, 8'(k * 16));
      applyStimulus(k, 8'(k * 16 + 1));
    end
    reAlways = 1'b1;
    planFromFifos();
    for (int i = 0; i < 8; i++) checkOutput("t4Plan", expWord[i], t4Exp[i]);
    waitDrained("t4", 200);
    reAlways = 1'b0;

    // Reset while a word is on offer: word dropped, priority back to channel 0.
    reDelay = 1000;
    applyStimulus(2, 8'h5A);
    planFromFifos();
    n = 0;
    while (empty && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5Offer", empty, 0);
    checkOutput("t5Din", din, 8'h5A);
    applyReset(1);
    reDelay = 0;
    applyStimulus(3, 8'hC3);
    applyStimulus(0, 8'hC0);
    planFromFifos();
    checkOutput("t5PlanFirst", expWord[0], 8'hC0);
    waitDrained("t5", 100);

    // Non-granted channels fill up mid-burst without disturbing the grant.
    applyStimulus(1, 8'hD0); applyStimulus(1, 8'hD1);
    expectWord(8'hD0, 1); expectWord(8'hD1, 1);
    repeat (2) @(negedge clk);
    applyStimulus(2, 8'hE0);
    applyStimulus(0, 8'hF0);
    expectWord(8'hE0, 2); expectWord(8'hF0, 0);
    mLastGrant = 0;
    waitDrained("t6", 100);

    // Slow transmitter: offers must hold until re arrives.
    reDelay = 3;
    applyStimulus(3, 8'h70); applyStimulus(3, 8'h71); applyStimulus(3, 8'h72);
    applyStimulus(0, 8'h99);
    planFromFifos();
    checkOutput("t7PlanGid", expGid[2], 0);
    checkOutput("t7PlanWord", expWord[3], 8'h72);
    waitDrained("t7", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 32'd4: number of source FIFOs sharing one transmitter_native (legal range 2..16).
REQ-002 SHALL have parameter WORD_WIDTH, default 32'd8: word width, equal to the transmitter's WORD_WIDTH.
REQ-003 SHALL have parameter BURST_LENGTH, default 32'd2: maximum words forwarded per grant (legal range ≥1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port src_din, input, NUM_CHANNELS*WORD_WIDTH: source FIFO read data; channel k occupies bits [k*WORD_WIDTH +: WORD_WIDTH]; valid the cycle after src_re[k].
REQ-007 SHALL have port src_empty, input, NUM_CHANNELS: per-channel source FIFO empty flag.
REQ-008 SHALL have port src_re, output, NUM_CHANNELS: per-channel source FIFO read enable.
REQ-009 SHALL have port din, output, WORD_WIDTH: word to the transmitter's din.
REQ-010 SHALL have port empty, output, 1: to the transmitter's empty; 0 means a word is offered.
REQ-011 SHALL have port re, input, 1: from the transmitter's re.
REQ-012 SHALL have port grant_id, output, max(1,$clog2(NUM_CHANNELS)): currently granted channel.
REQ-013 SHALL have port grant_valid, output, 1: 1 when a channel holds the grant.

Function
REQ-014 SHALL implement FSM states S_IDLE, S_FETCH, S_CAPTURE, S_OFFER, S_DRAIN.
REQ-015 S_IDLE: if any src_empty bit is 0, grant the first non-empty channel in round-robin order starting at last_grant+1 (mod NUM_CHANNELS), clear word_count, go S_FETCH; else stay.
REQ-016 S_FETCH: if src_empty[grant_id]=0, assert src_re[grant_id] for exactly this cycle and go S_CAPTURE; else assert nothing, set last_grant=grant_id and return to S_IDLE.
REQ-017 S_CAPTURE: register src_din of grant_id into the word register; go S_OFFER.
REQ-018 S_OFFER: drive empty=0; on re=1, increment word_count and go S_DRAIN; otherwise hold indefinitely.
REQ-019 S_DRAIN: drive empty=1 while keeping din unchanged, since the transmitter samples din the cycle after re.
REQ-020 S_DRAIN exit: if word_count<BURST_LENGTH and src_empty[grant_id]=0, go S_FETCH on the same channel; else set last_grant=grant_id and go S_IDLE.
REQ-021 din SHALL equal the word register at all times; the word register changes only in S_CAPTURE.
REQ-022 empty SHALL be 0 only in S_OFFER.
REQ-023 At most one src_re bit SHALL be high in any cycle, and only in S_FETCH.
REQ-024 grant_valid SHALL be 1 in S_FETCH, S_CAPTURE, S_OFFER and S_DRAIN; grant_id is stable while grant_valid=1.
REQ-025 re while not in S_OFFER SHALL be ignored, with no state or count change.
REQ-026 Changes on src_empty of non-granted channels SHALL NOT affect the current grant.
REQ-027 When BURST_LENGTH=1, the block SHALL perform pure per-word round-robin.
REQ-028 word_count SHALL be $clog2(BURST_LENGTH+1) bits wide and SHALL never exceed BURST_LENGTH.
REQ-029 Latency SHALL be 3 cycles from the S_IDLE decision edge to empty=0: S_FETCH → S_CAPTURE → S_OFFER.

Reset
REQ-030 While rst=1 at a clock edge, the next state SHALL be S_IDLE regardless of current state, with no src_re asserted in that cycle.
REQ-031 Reset values SHALL be: src_re=0, empty=1, din=0, grant_valid=0, grant_id=0, word_count=0, last_grant=NUM_CHANNELS-1, so channel 0 has first priority.
REQ-032 A word captured but not yet accepted by re at reset SHALL be discarded.

Verification (NUM_CHANNELS=4, BURST_LENGTH=2, WORD_WIDTH=8, re driven by bench unless stated)
REQ-033 Reset, all src_empty=1 → empty=1, src_re=4'b0000, din=8'h00, grant_valid=0 held for 20 cycles.
REQ-034 Channel 2 alone holds 8'h3C → src_re=4'b0100 for one cycle; din=8'h3C and empty=0 two cycles later; re pulse → empty=1 next cycle with din still 8'h3C.
REQ-035 Channel 0 holds A1,A2,A3 and channel 1 holds B1 → transmitted order A1,A2,B1,A3, with grant_id sequence 0,1,0.
REQ-036 All four channels each hold two words (k0,k1) → order 00,01,10,11,20,21,30,31; no src_re overlaps.
REQ-037 rst=1 for one cycle while in S_OFFER with din=8'h5A → next cycle empty=1, grant_valid=0; the word is not re-offered; arbitration restarts at channel 0.
REQ-038 Connected to transmitter_native (100 MHz, 115200 baud), channel 1 holds 8'hA5 → dout emits start 0, bits 1,0,1,0,0,1,0,1 (LSB first), stop 1, each 868 clocks; empty stays 1 after the transfer.
